ifu: RTL
========

IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, fetch-buffer entries and maximum outstanding-plus-buffered credit.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 jmp_en_i  input  1  redirect request from branch/jump control.
REQ-006 jmp_to_i  input  32  redirect target address.
REQ-007 hold_code_i  input  BUS_HOLD_CODE  pipeline hold code; any value other than HOLD_CODE_NOPE freezes the IF/ID output.
REQ-008 imem_req_o  output  1  instruction-memory request valid.
REQ-009 imem_addr_o  output  32  request address, word-aligned.
REQ-010 imem_gnt_i  input  1  request accepted this cycle.
REQ-011 imem_rvalid_i  input  1  in-order response valid; no backpressure.
REQ-012 imem_rdata_i  input  32  response instruction word.
REQ-013 instr_o  output  32  instruction to decode.
REQ-014 instr_addr_o  output  32  PC of instr_o.
REQ-015 instr_valid_o  output  1  instr_o is a real fetched instruction (0 = bubble).

Function
REQ-016 PC register holds next request address; imem_addr_o = PC at all times.
REQ-017 Request accepted when imem_req_o && imem_gnt_i; PC increments by 4 on acceptance, wraps 32'hFFFF_FFFC -> 0.
REQ-018 imem_req_o = 1 only when outstanding + fifo_count < FIFO_DEPTH and jmp_en_i = 0.
REQ-019 Outstanding counter: +1 on acceptance, -1 on a response; simultaneous +1/-1 leaves it unchanged; range 0..FIFO_DEPTH.
REQ-020 Each non-killed response pushes {addr, rdata} into the fetch FIFO; the address is taken from an in-order address tag queue.
REQ-021 The credit rule guarantees no push into a full FIFO; push and pop in the same cycle are allowed at any fill level.
REQ-022 Output update, when hold_code_i = HOLD_CODE_NOPE and jmp_en_i = 0: FIFO non-empty -> pop, instr_o/instr_addr_o load the head, instr_valid_o = 1; FIFO empty -> instr_o = NOP_INSTR, instr_valid_o = 0.
REQ-023 hold_code_i != HOLD_CODE_NOPE: outputs and FIFO are unchanged; requests continue subject to credit.
REQ-024 Redirect cycle (jmp_en_i = 1):
  - PC <= {jmp_to_i[31:2], 2'b00}
  - FIFO cleared
  - kill_cnt <= outstanding - imem_rvalid_i
  - imem_req_o = 0
  - next cycle instr_o = NOP_INSTR, instr_valid_o = 0
REQ-025 jmp_en_i takes priority over hold_code_i and over any FIFO pop.
REQ-026 While kill_cnt > 0, each response is dropped and decrements kill_cnt; responses arriving in the redirect cycle itself are dropped.
REQ-027 Redirect while kill_cnt > 0: kill_cnt <= kill_cnt + new outstanding from the current stream, minus the current response.
REQ-028 Latency: a grant at cycle N with rvalid at N+1 and no hold gives instr_valid_o = 1 at N+2.

Reset
REQ-029 rst_n low asynchronously sets:
  - PC = RESET_PC
  - imem_req_o = 0
  - instr_o = NOP_INSTR, instr_addr_o = RESET_PC, instr_valid_o = 0
  - FIFO empty, outstanding = 0, kill_cnt = 0
REQ-030 First imem_req_o = 1 occurs in the first cycle after rst_n deassertion.
REQ-031 Reset mid-operation discards all in-flight state; late responses after reset are not expected from memory, which resets together with the block.

Structure
REQ-032 The shared define file holds RESET_PC default, NOP_INSTR (32'h0000_0013), HOLD_CODE_* values, BUS_HOLD_CODE, and BUS_ADDR_MEM.
REQ-033 One sub-module, fetch_fifo: synchronous FIFO with parameters depth and width, and ports push, pop, clear, full, empty, count; it stores {addr, instr}.

Verification
REQ-034 Reset then 0-wait memory (gnt = 1, rvalid one cycle after gnt) -> instr_addr_o sequence 0, 4, 8, 12 with instr_valid_o = 1 from cycle 2.
REQ-035 hold_code_i = HOLD_CODE_ID for 3 cycles with 0-wait memory -> outputs frozen, imem_req_o drops once outstanding + count = 2, stream resumes with no skipped or duplicated address.
REQ-036 jmp_en_i = 1, jmp_to_i = 32'h0000_0103 with 2 outstanding -> next request address 32'h0000_0100, the 2 late responses dropped, first valid instr_addr_o = 32'h100.
REQ-037 jmp_en_i and hold_code_i = HOLD_CODE_ID in the same cycle -> redirect taken, instr_valid_o = 0 next cycle.
REQ-038 gnt held low 5 cycles -> imem_req_o stays high with a stable address; instr_valid_o = 0 after the FIFO drains.
REQ-039 rst_n pulsed low mid-stream with 2 outstanding -> outputs at reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// IFU shared definitions: reset PC, NOP encoding, hold codes,
// bus widths and the fetch-buffer entry layout.
package ifu_pkg;

  localparam int BUS_ADDR_MEM  = 32;
  localparam int BUS_HOLD_CODE = 3;

  localparam logic [BUS_ADDR_MEM-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [BUS_HOLD_CODE-1:0] HOLD_CODE_NOPE = 3'd0;
  localparam logic [BUS_HOLD_CODE-1:0] HOLD_CODE_IF   = 3'd1;
  localparam logic [BUS_HOLD_CODE-1:0] HOLD_CODE_ID   = 3'd2;
  localparam logic [BUS_HOLD_CODE-1:0] HOLD_CODE_EX   = 3'd3;

  typedef struct packed {
    logic [BUS_ADDR_MEM-1:0] addr;
    logic [31:0]             instr;
  } fetch_ent_t;

  function automatic logic [BUS_ADDR_MEM-1:0] word_align(
    input logic [BUS_ADDR_MEM-1:0] a
  );
    return {a[BUS_ADDR_MEM-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Synchronous FIFO with clear; push and pop may coincide at any
// fill level, and a push into a full FIFO is accepted only with a pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       clear,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign rdata  = r_mem[r_rp];
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  // storage write, no reset needed on data
  always_ff @(posedge clk) begin
    if (w_push & ~clear) r_mem[r_wp] <= wdata;
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= nxt(r_wp);
      if (w_pop)  r_rp <= nxt(r_rp);
      if (w_push & ~w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (w_pop & ~w_push) r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: credit-limited requests, in-order tag
// queue, fetch buffer, redirect with late-response kill.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     jmp_en_i,
  input  logic [31:0]              jmp_to_i,
  input  logic [BUS_HOLD_CODE-1:0] hold_code_i,
  output logic                     imem_req_o,
  output logic [31:0]              imem_addr_o,
  input  logic                     imem_gnt_i,
  input  logic                     imem_rvalid_i,
  input  logic [31:0]              imem_rdata_i,
  output logic [31:0]              instr_o,
  output logic [31:0]              instr_addr_o,
  output logic                     instr_valid_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int KW = 16;
  localparam int EW = $bits(fetch_ent_t);

  logic          r_run;
  logic [31:0]   r_pc;
  logic [KW-1:0] r_kill;
  logic [31:0]   r_instr;
  logic [31:0]   r_addr;
  logic          r_valid;

  logic [CW-1:0] w_cnt;
  logic [CW-1:0] w_out;
  logic          w_full;
  logic          w_empty;
  logic          w_tfull;
  logic          w_tempty;
  logic [31:0]   w_tag;
  fetch_ent_t    w_head;
  fetch_ent_t    w_new;
  logic          w_credit;
  logic          w_acc;
  logic          w_upd;
  logic          w_killed;
  logic          w_rsp;
  logic          w_byp;
  logic          w_push;
  logic          w_pop;

  assign w_credit = ({1'b0, w_out} + {1'b0, w_cnt}) < (CW+1)'(FIFO_DEPTH);
  assign imem_req_o  = r_run & ~jmp_en_i & w_credit & ~w_full & ~w_tfull;
  assign imem_addr_o = r_pc;

  assign w_acc    = imem_req_o & imem_gnt_i;
  assign w_upd    = ~jmp_en_i & (hold_code_i == HOLD_CODE_NOPE);
  assign w_killed = imem_rvalid_i & (jmp_en_i | (r_kill != '0));
  assign w_rsp    = imem_rvalid_i & ~w_killed & ~w_tempty;
  assign w_byp    = w_rsp & w_upd & w_empty;
  assign w_push   = w_rsp & ~w_byp;
  assign w_pop    = w_upd & ~w_empty;
  assign w_new    = '{addr: w_tag, instr: imem_rdata_i};

  assign instr_o       = r_instr;
  assign instr_addr_o  = r_addr;
  assign instr_valid_o = r_valid;

  // addresses of the live stream's outstanding requests
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tag (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_acc),
    .wdata (r_pc),
    .pop   (w_rsp),
    .clear (jmp_en_i),
    .rdata (w_tag),
    .full  (w_tfull),
    .empty (w_tempty),
    .count (w_out)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (w_new),
    .pop   (w_pop),
    .clear (jmp_en_i),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_cnt)
  );

  // run flag keeps requests off until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // next request address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_pc <= RESET_PC;
    else if (jmp_en_i) r_pc <= word_align(jmp_to_i);
    else if (w_acc)    r_pc <= r_pc + 32'd4;
  end

  // responses still owed to abandoned streams
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_kill <= '0;
    else if (jmp_en_i)
      r_kill <= r_kill + KW'(w_out) - KW'(imem_rvalid_i);
    else if (w_killed)
      r_kill <= r_kill - KW'(1);
  end

  // IF/ID output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP_INSTR;
      r_addr  <= RESET_PC;
      r_valid <= 1'b0;
    end else if (jmp_en_i) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (w_upd) begin
      if (!w_empty) begin
        r_instr <= w_head.instr;
        r_addr  <= w_head.addr;
        r_valid <= 1'b1;
      end else if (w_byp) begin
        r_instr <= imem_rdata_i;
        r_addr  <= w_tag;
        r_valid <= 1'b1;
      end else begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end
    end
  end

endmodule
